audio_stream_fifo: RTL and testbench

//  Buffered, parametrised streaming front-end for the audio CODEC driver. Converts the driver's
//  one-cycle 48 kHz advance strobe into valid/ready streams: a playback FIFO feeds dac_left/right,
//  a capture FIFO collects adc_left/right. Adds configurable sample width, FIFO depth, mono mode,

---
 rtl/audio_stream_fifo.sv | 118 +++++++++++
 tb/tb_audio_stream_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_fifo.sv
// rtl/audio_stream_fifo.sv - playback/capture stream FIFOs between user logic and the CODEC driver
module audio_stream_fifo #(
   parameter int SAMPLE_W      = 24,
   parameter int DEPTH         = 16,
   parameter int MONO          = 0,
   parameter int UNDERRUN_HOLD = 0,
   parameter int CNT_W         = 16
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      clear_stats,
   input  logic                      advance,
   input  logic [23:0]               adc_left,
   input  logic [23:0]               adc_right,
   output logic [23:0]               dac_left,
   output logic [23:0]               dac_right,
   input  logic                      play_valid,
   output logic                      play_ready,
   input  logic [2*SAMPLE_W-1:0]     play_data,
   output logic                      cap_valid,
   input  logic                      cap_ready,
   output logic [2*SAMPLE_W-1:0]     cap_data,
   output logic [$clog2(DEPTH):0]    play_level,
   output logic [CNT_W-1:0]          underruns,
   output logic [CNT_W-1:0]          overflows
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = 2 * SAMPLE_W;

   logic [PW-1:0] play_mem [DEPTH];
   logic [PW-1:0] cap_mem  [DEPTH];
   logic [AW:0]   play_wr, play_rd, cap_wr, cap_rd;
   logic          play_full, play_empty, cap_full, cap_empty;
   logic          tick, play_push, play_pop, cap_push, cap_pop;
   logic [PW-1:0] play_head, last_pair, dac_src;
   logic [23:0]   cap_right_src;
   logic [PW-1:0] cap_in;

   function automatic logic [23:0] widen(input logic [SAMPLE_W-1:0] s);
      logic [23:0] w;
      w = '0;
      w[23 -: SAMPLE_W] = s;
      return w;
   endfunction

   assign play_empty = (play_wr == play_rd);
   assign play_full  = (play_wr[AW] != play_rd[AW]) && (play_wr[AW-1:0] == play_rd[AW-1:0]);
   assign cap_empty  = (cap_wr == cap_rd);
   assign cap_full   = (cap_wr[AW] != cap_rd[AW]) && (cap_wr[AW-1:0] == cap_rd[AW-1:0]);

   assign tick       = advance & enable;
   assign play_push  = play_valid & ~play_full;
   assign play_pop   = tick & ~play_empty;
   assign cap_push   = tick & ~cap_full;
   assign cap_pop    = cap_ready & ~cap_empty;

   assign play_ready = ~play_full;
   assign play_level = play_wr - play_rd;
   assign cap_valid  = ~cap_empty;
   assign cap_data   = cap_mem[cap_rd[AW-1:0]];
   assign play_head  = play_mem[play_rd[AW-1:0]];

   // Underrun source: zero, or the last pair actually played when holding
   assign dac_src = ~play_empty ? play_head :
                    (UNDERRUN_HOLD != 0) ? last_pair : '0;

   assign cap_right_src = (MONO != 0) ? adc_left : adc_right;
   assign cap_in        = {adc_left[23 -: SAMPLE_W], cap_right_src[23 -: SAMPLE_W]};

   always_ff @(posedge CLOCK_50) begin
      if (play_push) play_mem[play_wr[AW-1:0]] <= play_data;
      if (cap_push)  cap_mem[cap_wr[AW-1:0]]   <= cap_in;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         play_wr <= '0;
         play_rd <= '0;
         cap_wr  <= '0;
         cap_rd  <= '0;
      end else begin
         if (play_push) play_wr <= play_wr + 1'b1;
         if (play_pop)  play_rd <= play_rd + 1'b1;
         if (cap_push)  cap_wr  <= cap_wr + 1'b1;
         if (cap_pop)   cap_rd  <= cap_rd + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         dac_left  <= '0;
         dac_right <= '0;
         last_pair <= '0;
      end else if (!enable) begin
         dac_left  <= '0;
         dac_right <= '0;
      end else if (advance) begin
         dac_left  <= widen(dac_src[PW-1 -: SAMPLE_W]);
         dac_right <= (MONO != 0) ? widen(dac_src[PW-1 -: SAMPLE_W])
                                  : widen(dac_src[SAMPLE_W-1:0]);
         if (!play_empty) last_pair <= play_head;
      end
   end

   // Saturating counters; clear_stats wins over a same-cycle increment
   always_ff @(posedge CLOCK_50) begin
      if (reset || clear_stats) begin
         underruns <= '0;
         overflows <= '0;
      end else begin
         if (tick && play_empty && !(&underruns)) underruns <= underruns + 1'b1;
         if (tick && cap_full && !(&overflows))   overflows <= overflows + 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_stream_fifo.sv
// tb/tb_audio_stream_fifo.sv - randomized model-checked bench for audio_stream_fifo (two configurations)
module tb_audio_stream_fifo;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1, enable = 1'b1, clear_stats = 1'b0, advance = 1'b0;
   logic [23:0] adc_left = '0, adc_right = '0;
   logic        play_valid = 1'b0, cap_ready = 1'b0;
   logic [47:0] play_data0 = '0;
   logic [31:0] play_data1 = '0;

   logic [23:0] dac_left0, dac_right0, dac_left1, dac_right1;
   logic        play_ready0, play_ready1, cap_valid0, cap_valid1;
   logic [47:0] cap_data0;
   logic [31:0] cap_data1;
   logic [4:0]  play_level0;
   logic [2:0]  play_level1;
   logic [15:0] underruns0, overflows0;
   logic [3:0]  underruns1, overflows1;

   always #10 CLOCK_50 = ~CLOCK_50;

   audio_stream_fifo #(.SAMPLE_W(24), .DEPTH(16), .MONO(1), .UNDERRUN_HOLD(0), .CNT_W(16)) u0 (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear_stats(clear_stats),
      .advance(advance), .adc_left(adc_left), .adc_right(adc_right),
      .dac_left(dac_left0), .dac_right(dac_right0),
      .play_valid(play_valid), .play_ready(play_ready0), .play_data(play_data0),
      .cap_valid(cap_valid0), .cap_ready(cap_ready), .cap_data(cap_data0),
      .play_level(play_level0), .underruns(underruns0), .overflows(overflows0));

   audio_stream_fifo #(.SAMPLE_W(16), .DEPTH(4), .MONO(0), .UNDERRUN_HOLD(1), .CNT_W(4)) u1 (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear_stats(clear_stats),
      .advance(advance), .adc_left(adc_left), .adc_right(adc_right),
      .dac_left(dac_left1), .dac_right(dac_right1),
      .play_valid(play_valid), .play_ready(play_ready1), .play_data(play_data1),
      .cap_valid(cap_valid1), .cap_ready(cap_ready), .cap_data(cap_data1),
      .play_level(play_level1), .underruns(underruns1), .overflows(overflows1));

   localparam int DEP  [2] = '{16, 4};
   localparam int SW   [2] = '{24, 16};
   localparam int HOLD [2] = '{0, 1};
   localparam int MON  [2] = '{1, 0};
   localparam int CMAX [2] = '{65535, 15};

   // Reference model: FIFOs as plain lists, index 0 is the oldest entry
   logic [47:0] mp [2][16];
   logic [47:0] mc [2][16];
   int          np [2], nc [2];
   logic [47:0] mlast [2];
   logic [23:0] mdl [2], mdr [2];
   int          mund [2], movf [2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input int k, input logic [47:0] pd);
      logic [47:0] mask, src, lft, rgt, cv;
      int pre_np, pre_nc;
      bit und_inc, ovf_inc;
      if (reset) begin
         np[k] = 0; nc[k] = 0; mlast[k] = '0; mdl[k] = '0; mdr[k] = '0;
         mund[k] = 0; movf[k] = 0;
         return;
      end
      mask = (48'd1 << SW[k]) - 48'd1;
      pre_np = np[k];
      pre_nc = nc[k];
      und_inc = 0;
      ovf_inc = 0;
      if (!enable) begin
         mdl[k] = '0;
         mdr[k] = '0;
      end else if (advance) begin
         if (pre_np > 0) begin
            src = mp[k][0];
            mlast[k] = src;
            for (int i = 0; i < 15; i++) mp[k][i] = mp[k][i+1];
            np[k]--;
         end else begin
            und_inc = 1;
            src = (HOLD[k] != 0) ? mlast[k] : 48'd0;
         end
         lft = (src >> SW[k]) & mask;
         rgt = src & mask;
         mdl[k] = 24'(lft << (24 - SW[k]));
         mdr[k] = (MON[k] != 0) ? mdl[k] : 24'(rgt << (24 - SW[k]));
      end
      if (play_valid && pre_np < DEP[k]) begin
         mp[k][np[k]] = pd & ((48'd1 << (2 * SW[k])) - 48'd1);
         np[k]++;
      end
      if (cap_ready && pre_nc > 0) begin
         for (int i = 0; i < 15; i++) mc[k][i] = mc[k][i+1];
         nc[k]--;
      end
      if (enable && advance) begin
         if (pre_nc < DEP[k]) begin
            lft = 48'(adc_left) >> (24 - SW[k]);
            rgt = 48'((MON[k] != 0) ? adc_left : adc_right) >> (24 - SW[k]);
            cv = (lft << SW[k]) | rgt;
            mc[k][nc[k]] = cv;
            nc[k]++;
         end else begin
            ovf_inc = 1;
         end
      end
      if (clear_stats) begin
         mund[k] = 0;
         movf[k] = 0;
      end else begin
         if (und_inc && mund[k] < CMAX[k]) mund[k]++;
         if (ovf_inc && movf[k] < CMAX[k]) movf[k]++;
      end
   endtask

   task automatic compare_all();
      check("u0_dac_left",   dac_left0,   mdl[0]);
      check("u0_dac_right",  dac_right0,  mdr[0]);
      check("u0_play_ready", play_ready0, np[0] < DEP[0]);
      check("u0_play_level", play_level0, np[0]);
      check("u0_cap_valid",  cap_valid0,  nc[0] > 0);
      if (nc[0] > 0) check("u0_cap_data", cap_data0, mc[0][0]);
      check("u0_underruns",  underruns0,  mund[0]);
      check("u0_overflows",  overflows0,  movf[0]);
      check("u1_dac_left",   dac_left1,   mdl[1]);
      check("u1_dac_right",  dac_right1,  mdr[1]);
      check("u1_play_ready", play_ready1, np[1] < DEP[1]);
      check("u1_play_level", play_level1, np[1]);
      check("u1_cap_valid",  cap_valid1,  nc[1] > 0);
      if (nc[1] > 0) check("u1_cap_data", cap_data1, mc[1][0]);
      check("u1_underruns",  underruns1,  mund[1]);
      check("u1_overflows",  overflows1,  movf[1]);
   endtask

   task automatic step();
      model_step(0, play_data0);
      model_step(1, {16'h0, play_data1});
      @(posedge CLOCK_50);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      reset = 0; enable = 1; clear_stats = 0; advance = 0;
      play_valid = 0; cap_ready = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   initial begin
      logic [63:0] r;
      int pbias, cbias;

      do_reset();
      check("rst_dac_left", dac_left0, 24'h0);
      check("rst_play_ready", play_ready1, 1'b1);

      // Three pairs then four advances: pair1, pair2, pair3, then underrun
      for (int i = 1; i <= 3; i++) begin
         play_valid = 1;
         play_data0 = {24'(i * 24'h111111), 24'(i * 24'h222222)};
         play_data1 = {16'(i * 16'h1111), 16'(i * 16'h0101)};
         step();
      end
      play_valid = 0;
      for (int a = 1; a <= 4; a++) begin
         advance = 1;
         step();
         check("dir_dac_seq", dac_left0, (a < 4) ? 24'(a * 24'h111111) : 24'h0);
         check("dir_hold_seq", dac_left1, {16'(((a < 4) ? a : 3) * 16'h1111), 8'h00});
         advance = 0;
         step();
      end
      check("dir_underruns", underruns0, 16'd1);

      // Fill DEPTH=4 with six pushes and no advance
      do_reset();
      play_valid = 1;
      for (int i = 0; i < 6; i++) begin
         play_data1 = 32'hA000_0000 + 32'(i);
         play_data0 = 48'(i);
         step();
      end
      play_valid = 0;
      check("dir_full_ready", play_ready1, 1'b0);
      check("dir_full_level", play_level1, 3'd4);

      // Capture overflow with ramp, counters saturating on the small instance
      do_reset();
      for (int i = 0; i < 18; i++) begin
         advance = 1;
         adc_left = 24'(i * 24'h010101);
         adc_right = 24'(24'hFFFFFF - i);
         step();
      end
      advance = 0;
      check("dir_overflows", overflows0, 16'd2);
      check("dir_sat_und", underruns1, 4'hF);
      advance = 1;
      step();
      check("dir_sat_hold", underruns1, 4'hF);
      clear_stats = 1;
      step();
      check("dir_clear_prio", underruns1, 4'h0);
      clear_stats = 0;
      advance = 0;

      // Width conversion on the 16-bit instance
      do_reset();
      play_valid = 1;
      play_data1 = {16'hABCD, 16'h1234};
      step();
      play_valid = 0;
      advance = 1;
      step();
      advance = 0;
      check("dir_w16_left", dac_left1, 24'hABCD00);
      check("dir_w16_right", dac_right1, 24'h123400);

      // Disabled: advance ignored, dac driven to zero
      enable = 0;
      advance = 1;
      step();
      check("dir_disable_dac", dac_left1, 24'h0);
      idle_inputs();

      // Randomized traffic with changing fill/drain biases and rare resets
      for (int c = 0; c < 3000; c++) begin
         pbias = (c / 300) % 3;
         cbias = (c / 450) % 3;
         reset       = ($urandom_range(0, 599) == 0);
         enable      = ($urandom_range(0, 9) != 0);
         advance     = ($urandom_range(0, 3) == 0);
         clear_stats = ($urandom_range(0, 149) == 0);
         play_valid  = ($urandom_range(0, 3) < pbias + 1);
         cap_ready   = ($urandom_range(0, 3) < cbias + 1);
         r = {$urandom(), $urandom()};
         play_data0 = r[47:0];
         play_data1 = r[63:32];
         r = {$urandom(), $urandom()};
         adc_left  = r[23:0];
         adc_right = r[55:32];
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
